// File: rtl/down_counter.sv
// Loadable down counter with an IDLE/RUN/DONE control FSM and a one-cycle done pulse.
// Latency: count and busy update one edge after start; done follows load_val enabled cycles later.
// Optional DOWN_COUNTER_AUTO_RELOAD_EN: DONE reloads load_val and re-enters RUN instead of IDLE.
module down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  // State and count register; reset wins, start beats enable, and a zero load jumps straight to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= ZERO;
    end else if (start) begin
      if (load_val != ZERO) begin
        count <= load_val;
        state <= RUN;
      end else begin
        count <= ZERO;
        state <= DONE;
      end
    end else begin
      case (state)
        IDLE: begin
          state <= IDLE;
        end
        RUN: begin
          if (enable) begin
            if (count > ONE) begin
              count <= count - ONE;
            end else begin
              // count==1 finishes; count==0 cannot occur in RUN but is clamped rather than wrapped
              count <= ZERO;
              state <= DONE;
            end
          end
        end
        DONE: begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
          if (load_val != ZERO) begin
            count <= load_val;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end
        default: begin
          state <= IDLE;
          count <= ZERO;
        end
      endcase
    end
  end

  // Status outputs decoded straight from registered state/count.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
    tc   = (count == ZERO);
  end

endmodule

// File: tb/tb_down_counter.sv
// Directed bench for down_counter (WIDTH=4); inputs change 1 time unit after the rising edge,
// outputs are sampled at the same point, i.e. after the edge has settled.
module tb_down_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] load_val;
  logic       enable;
  logic [3:0] count;
  logic       busy;
  logic       done;
  logic       tc;

  int n_tests = 0;
  int n_fail  = 0;

  down_counter #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .load_val (load_val),
    .enable   (enable),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .tc       (tc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare all four outputs against hand-derived values; tc is implied by the expected count.
  task automatic expect_out(input string tag, input int c, input int b, input int d);
    check({tag, ".count"}, int'(count), c);
    check({tag, ".busy"},  int'(busy),  b);
    check({tag, ".done"},  int'(done),  d);
    check({tag, ".tc"},    int'(tc),    (c == 0) ? 1 : 0);
  endtask

  initial begin
    int e;
    rst = 1'b1; start = 1'b0; load_val = 4'd0; enable = 1'b0;

    // Reset held two cycles
    tick(); tick();
    rst = 1'b0;
    expect_out("reset", 0, 0, 0);
    tick();
    expect_out("idle_hold", 0, 0, 0);

    // load 5, enable high: 5,4,3,2,1,0/done, then idle
    start = 1'b1; load_val = 4'd5; enable = 1'b1;
    tick();
    start = 1'b0; load_val = 4'd0;
    expect_out("l5_c5", 5, 1, 0);
    tick(); expect_out("l5_c4", 4, 1, 0);
    tick(); expect_out("l5_c3", 3, 1, 0);
    tick(); expect_out("l5_c2", 2, 1, 0);
    tick(); expect_out("l5_c1", 1, 1, 0);
    tick(); expect_out("l5_done", 0, 0, 1);
    tick(); expect_out("l5_idle", 0, 0, 0);

    // load 6 with enable toggling: only enabled cycles decrement
    start = 1'b1; load_val = 4'd6; enable = 1'b1;
    tick();
    start = 1'b0; load_val = 4'd0;
    expect_out("l6_load", 6, 1, 0);
    e = 6;
    for (int i = 0; i < 11; i++) begin
      enable = (i % 2 == 0);
      tick();
      if (enable) e = e - 1;
      expect_out($sformatf("l6_step%0d", i), e, (e != 0) ? 1 : 0, (e == 0) ? 1 : 0);
    end
    enable = 1'b0;
    tick(); expect_out("l6_idle", 0, 0, 0);

    // load 9, restart with 3 when count hits 4
    start = 1'b1; load_val = 4'd9; enable = 1'b1;
    tick();
    start = 1'b0; load_val = 4'd0;
    expect_out("l9_load", 9, 1, 0);
    for (int i = 8; i >= 4; i--) begin
      tick(); expect_out($sformatf("l9_c%0d", i), i, 1, 0);
    end
    start = 1'b1; load_val = 4'd3;
    tick();
    start = 1'b0; load_val = 4'd0;
    expect_out("restart_c3", 3, 1, 0);
    tick(); expect_out("restart_c2", 2, 1, 0);
    tick(); expect_out("restart_c1", 1, 1, 0);
    tick(); expect_out("restart_done", 0, 0, 1);
    tick(); expect_out("restart_idle", 0, 0, 0);

    // zero load goes straight to DONE, busy never set
    start = 1'b1; load_val = 4'd0;
    tick();
    start = 1'b0;
    expect_out("l0_done", 0, 0, 1);
    tick(); expect_out("l0_idle", 0, 0, 0);

    // enable low in RUN holds the count
    start = 1'b1; load_val = 4'd4; enable = 1'b1;
    tick();
    start = 1'b0; load_val = 4'd0;
    expect_out("l4_load", 4, 1, 0);
    tick(); expect_out("l4_c3", 3, 1, 0);
    enable = 1'b0;
    tick(); expect_out("l4_hold", 3, 1, 0);
    enable = 1'b1;
    tick(); expect_out("l4_c2", 2, 1, 0);
    // reset mid-RUN: no done pulse afterwards
    rst = 1'b1;
    tick(); expect_out("rst_run", 0, 0, 0);
    rst = 1'b0;
    tick(); expect_out("rst_run_after", 0, 0, 0);

    // reset beats start
    rst = 1'b1; start = 1'b1; load_val = 4'd7;
    tick(); expect_out("rst_over_start", 0, 0, 0);
    // first start after reset is accepted on the next edge
    rst = 1'b0; load_val = 4'd2;
    tick();
    start = 1'b0; load_val = 4'd0;
    expect_out("post_rst_start", 2, 1, 0);
    tick(); expect_out("prs_c1", 1, 1, 0);
    tick(); expect_out("prs_done", 0, 0, 1);

    // start during DONE restarts instead of exiting
    start = 1'b1; load_val = 4'd1;
    tick();
    start = 1'b0; load_val = 4'd0;
    expect_out("l1_load", 1, 1, 0);
    tick(); expect_out("l1_done", 0, 0, 1);
    start = 1'b1; load_val = 4'd2;
    tick();
    start = 1'b0; load_val = 4'd0;
    expect_out("done_restart", 2, 1, 0);
    // reset while in DONE
    tick(); expect_out("dr_c1", 1, 1, 0);
    tick(); expect_out("dr_done", 0, 0, 1);
    rst = 1'b1; load_val = 4'd9;
    tick(); expect_out("rst_done", 0, 0, 0);
    rst = 1'b0; load_val = 4'd0;

    // maximum load value
    start = 1'b1; load_val = 4'd15;
    tick();
    start = 1'b0; load_val = 4'd0;
    expect_out("l15_load", 15, 1, 0);
    tick(); expect_out("l15_c14", 14, 1, 0);
    rst = 1'b1;
    tick(); rst = 1'b0;
    expect_out("l15_rst", 0, 0, 0);

    // load_val=3 held: periodic reload with the macro, single pulse without
    start = 1'b1; load_val = 4'd3; enable = 1'b1;
    tick();
    start = 1'b0;
    expect_out("p_c3", 3, 1, 0);
    tick(); expect_out("p_c2", 2, 1, 0);
    tick(); expect_out("p_c1", 1, 1, 0);
    tick(); expect_out("p_done", 0, 0, 1);
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    tick(); expect_out("p_reload_c3", 3, 1, 0);
    tick(); expect_out("p_reload_c2", 2, 1, 0);
    tick(); expect_out("p_reload_c1", 1, 1, 0);
    tick(); expect_out("p_done2", 0, 0, 1);
    load_val = 4'd0;
    tick(); expect_out("p_idle", 0, 0, 0);
`else
    tick(); expect_out("p_idle", 0, 0, 0);
    tick(); expect_out("p_idle2", 0, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
